// File: rtl/decode_stage.sv
// Instruction decode stage: assembles one- or two-word instructions into a single
// registered decode entry with valid/ready handshakes. DECODE_STALL_COUNT_EN adds stall_cnt.
module decode_stage #(
    parameter int             IW        = 16,
    parameter logic [15:0]    S_OP_MASK = 16'hF000,
    parameter logic [255:0]   LONG_MASK = 256'h0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    op_dk,
    output logic [3:0]    op_s,
    output logic [3:0]    s,
    output logic [6:0]    d,
    output logic [7:0]    k,
    output logic          arp,
    output logic          s_type,
    output logic          two_word,
`ifdef DECODE_STALL_COUNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic [IW-1:0] imm
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] held_reg, held_next;
    logic [IW-1:0] first_reg, first_next;
    logic [IW-1:0] imm_reg, imm_next;
    logic          out_valid_reg, out_valid_next;
    logic          s_type_reg, s_type_next;
    logic          two_word_reg, two_word_next;
    logic          accept;

    always_comb begin
        state_next     = state_reg;
        held_next      = held_reg;
        first_next     = first_reg;
        imm_next       = imm_reg;
        out_valid_next = out_valid_reg;
        s_type_next    = s_type_reg;
        two_word_next  = two_word_reg;

        in_ready = !reset && !flush && (!out_valid_reg || out_ready);
        accept   = in_valid && in_ready;

        // A drain clears the entry; a load in the same cycle overrides it below.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LONG_MASK[instr[IW-1 -: 8]]) begin
                        held_next  = instr;
                        state_next = WAIT_IMM;
                    end else begin
                        first_next     = instr;
                        imm_next       = '0;
                        two_word_next  = 1'b0;
                        s_type_next    = S_OP_MASK[instr[IW-1 -: 4]];
                        out_valid_next = 1'b1;
                    end
                end
            end
            WAIT_IMM: begin
                if (accept) begin
                    first_next     = held_reg;
                    imm_next       = instr;
                    two_word_next  = LONG_MASK[held_reg[IW-1 -: 8]];
                    s_type_next    = S_OP_MASK[held_reg[IW-1 -: 4]];
                    out_valid_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (flush) begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
            held_next      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            held_reg      <= '0;
            first_reg     <= '0;
            imm_reg       <= '0;
            out_valid_reg <= 1'b0;
            s_type_reg    <= 1'b0;
            two_word_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            held_reg      <= held_next;
            first_reg     <= first_next;
            imm_reg       <= imm_next;
            out_valid_reg <= out_valid_next;
            s_type_reg    <= s_type_next;
            two_word_reg  <= two_word_next;
        end
    end

    // Field outputs are slices of the registered first word, so they hold while invalid.
    assign out_valid = out_valid_reg;
    assign op_dk     = first_reg[IW-1 -: 8];
    assign op_s      = first_reg[IW-1 -: 4];
    assign s         = first_reg[IW-5 -: 4];
    assign d         = first_reg[6:0];
    assign k         = first_reg[7:0];
    assign arp       = first_reg[7];
    assign s_type    = s_type_reg;
    assign two_word  = two_word_reg;
    assign imm       = imm_reg;

`ifdef DECODE_STALL_COUNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (out_valid_reg && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_decode_stage;

    localparam int           IW       = 16;
    localparam logic [15:0]  TB_SMASK = 16'hF000;
    localparam logic [255:0] TB_LONG  = (256'd1 << 8'h3C) | (256'd1 << 8'hA5) | (256'd1 << 8'h11);

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0] instr, imm;
    logic [7:0]    op_dk, k;
    logic [3:0]    op_s, s;
    logic [6:0]    d;
    logic          arp, s_type, two_word;
`ifdef DECODE_STALL_COUNT_EN
    logic [15:0]   stall_cnt;
`endif

    decode_stage #(.IW(IW), .S_OP_MASK(TB_SMASK), .LONG_MASK(TB_LONG)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .op_dk(op_dk),
        .op_s(op_s), .s(s), .d(d), .k(k), .arp(arp), .s_type(s_type), .two_word(two_word),
`ifdef DECODE_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .imm(imm)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    // Reference model: the current output entry, the pending first word and the stall count.
    logic        m_valid, m_tw, m_st, m_pend, m_rdy, obs_rdy;
    logic [15:0] m_first, m_imm, m_pword, m_stall;

    logic [50:0] dut_bus;
    assign dut_bus = {out_valid, op_dk, op_s, s, d, k, arp, s_type, two_word, imm};

    function automatic logic long_of(input logic [15:0] w);
        return 1'(TB_LONG >> (w >> 8));
    endfunction

    function automatic logic stype_of(input logic [15:0] w);
        return 1'(TB_SMASK >> (w >> 12));
    endfunction

    function automatic logic [50:0] exp_bus();
        return {m_valid, 8'(m_first >> 8), 4'(m_first >> 12), 4'((m_first >> 8) & 16'hF),
                7'(m_first & 16'h7F), 8'(m_first & 16'hFF), 1'(m_first >> 7), m_st, m_tw, m_imm};
    endfunction

    task automatic load_entry(input logic [15:0] a, input logic [15:0] b);
        m_first = a;
        m_imm   = b;
        m_tw    = long_of(a);
        m_st    = stype_of(a);
        m_valid = 1'b1;
        n_txn++;
        $display("txn %0d: first=%h imm=%h two_word=%0b s_type=%0b", n_txn, a, b, m_tw, m_st);
    endtask

    // Drive one cycle of inputs, sample in_ready mid-cycle, advance the model, land at edge+1.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [15:0] w, input logic o);
        logic acc;
        reset = r; flush = f; in_valid = iv; instr = w; out_ready = o;
        @(negedge clk);
        obs_rdy = in_ready;
        m_rdy   = !r && !f && (!m_valid || o);
        acc     = iv && m_rdy;
        if (r) m_stall = 16'h0;
        else if (m_valid && !o && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (r) begin
            m_valid = 1'b0; m_pend = 1'b0; m_pword = 16'h0;
            m_first = 16'h0; m_imm = 16'h0; m_tw = 1'b0; m_st = 1'b0;
        end else if (f) begin
            m_valid = 1'b0; m_pend = 1'b0; m_pword = 16'h0;
        end else begin
            if (m_valid && o) m_valid = 1'b0;
            if (acc) begin
                if (m_pend) begin
                    load_entry(m_pword, w);
                    m_pend = 1'b0;
                end else if (long_of(w)) begin
                    m_pend  = 1'b1;
                    m_pword = w;
                end else begin
                    load_entry(w, 16'h0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b1);
            n_cmp++;
            if (obs_rdy !== 1'b0) begin
                n_fail++; $display("FAIL reset_in_ready: got %b want 0", obs_rdy);
            end
            n_cmp++;
            if (dut_bus !== 51'h0) begin
                n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_bus);
            end
        end
`ifdef DECODE_STALL_COUNT_EN
        n_cmp++;
        if (stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt);
        end
`endif
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (obs_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", obs_rdy);
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b0, 1'b1, 16'h8A93, 1'b1);
        n_cmp++;
        if ({out_valid, op_dk, op_s, s, k, d, arp, imm, two_word} !==
            {1'b1, 8'h8A, 4'h8, 4'hA, 8'h93, 7'h13, 1'b1, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL single_fields: got %h want model %h", dut_bus, exp_bus());
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if ({out_valid, op_dk, k} !== {1'b0, 8'h8A, 8'h93}) begin
            n_fail++; $display("FAIL single_drain_hold: got %h want model %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_two_word();
        cycle(1'b0, 1'b0, 1'b1, 16'h3C05, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL two_word_first_no_output: got %b want 0", out_valid);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        n_cmp++;
        if ({out_valid, op_dk, k, imm, two_word} !== {1'b1, 8'h3C, 8'h05, 16'hBEEF, 1'b1}) begin
            n_fail++; $display("FAIL two_word_output: got %h want model %h", dut_bus, exp_bus());
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = m_stall;
        cycle(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0);
            n_cmp++;
            if (obs_rdy !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, obs_rdy);
            end
            n_cmp++;
            if ({out_valid, op_dk, k, imm} !== {1'b1, 8'h12, 8'h34, 16'h0}) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got %h want model %h", i, dut_bus, exp_bus());
            end
        end
`ifdef DECODE_STALL_COUNT_EN
        n_cmp++;
        if (stall_cnt !== base + 16'd5) begin
            n_fail++; $display("FAIL bp_stall_cnt: got %h want %h", stall_cnt, base + 16'd5);
        end
`endif
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 16'h3C05, 1'b0);
        n_cmp++;
        if ({obs_rdy, out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL flush_entry: got rdy=%b valid=%b want 0 0", obs_rdy, out_valid);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h3C05, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1);
        n_cmp++;
        if ({obs_rdy, out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL flush_wait_imm: got rdy=%b valid=%b want 0 0", obs_rdy, out_valid);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0042, 1'b1);
        n_cmp++;
        if ({out_valid, op_dk, k, imm, two_word} !== {1'b1, 8'h00, 8'h42, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL flush_then_single: got %h want model %h", dut_bus, exp_bus());
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [8];
        words = '{16'hF001, 16'h0102, 16'h2233, 16'hC4D5, 16'h7E7F, 16'hE080, 16'h5A5A, 16'h9F00};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, words[i], 1'b1);
            n_cmp++;
            if (obs_rdy !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready: word %0d got %b want 1", i, obs_rdy);
            end
            n_cmp++;
            if ({out_valid, op_dk, k, imm, s_type} !==
                {1'b1, words[i], 16'h0, 1'(words[i] >= 16'hC000)}) begin
                n_fail++; $display("FAIL stream_word: word %0d got %h want first=%h", i, dut_bus, words[i]);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b1, 16'h9F77, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0);
        n_cmp++;
        if (dut_bus !== 51'h0) begin
            n_fail++; $display("FAIL reset_mid_valid: got %h want 0", dut_bus);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'hA512, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (dut_bus !== 51'h0) begin
            n_fail++; $display("FAIL reset_mid_wait_imm: got %h want 0", dut_bus);
        end
`ifdef DECODE_STALL_COUNT_EN
        n_cmp++;
        if (stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid_stall_cnt: got %h want 0", stall_cnt);
        end
`endif
        cycle(1'b0, 1'b0, 1'b1, 16'h0042, 1'b1);
        n_cmp++;
        if ({out_valid, op_dk, k, imm, two_word} !== {1'b1, 8'h00, 8'h42, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_idle: got %h want model %h", dut_bus, exp_bus());
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0]  ops [3];
        logic [15:0] w;
        ops = '{8'h3C, 8'hA5, 8'h11};
        for (int i = 0; i < 600; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w = {ops[$urandom_range(0, 2)], w[7:0]};
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6);
            n_cmp++;
            if (obs_rdy !== m_rdy) begin
                n_fail++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", i, obs_rdy, m_rdy);
            end
            n_cmp++;
            if (dut_bus !== exp_bus()) begin
                n_fail++; $display("FAIL rand_outputs: cycle %0d got %h want %h", i, dut_bus, exp_bus());
            end
`ifdef DECODE_STALL_COUNT_EN
            n_cmp++;
            if (stall_cnt !== m_stall) begin
                n_fail++; $display("FAIL rand_stall_cnt: cycle %0d got %h want %h", i, stall_cnt, m_stall);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_tw = 1'b0; m_st = 1'b0; m_pend = 1'b0; m_rdy = 1'b0; obs_rdy = 1'b0;
        m_first = '0; m_imm = '0; m_pword = '0; m_stall = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_two_word();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
